// File: rtl/chrontel_pkg.sv
// Shared definitions for the Chrontel configuration sequencer: FSM states and
// the register init table walked in index order.
package chrontel_pkg;

  localparam int unsigned CH_NUM_REGS = 8;

  typedef enum logic [3:0] {
    StIdle,
    StRstHold,
    StRstRecover,
    StIssueWr,
    StWaitWr,
    StIssueRd,
    StWaitRd,
    StNext,
    StDone,
    StError
  } ch_state_e;

  function automatic logic [7:0] ch_reg_addr(input logic [2:0] idx);
    case (idx)
      3'd0:    ch_reg_addr = 8'h1C;
      3'd1:    ch_reg_addr = 8'h1D;
      3'd2:    ch_reg_addr = 8'h1F;
      3'd3:    ch_reg_addr = 8'h21;
      3'd4:    ch_reg_addr = 8'h33;
      3'd5:    ch_reg_addr = 8'h34;
      3'd6:    ch_reg_addr = 8'h36;
      default: ch_reg_addr = 8'h49;
    endcase
  endfunction

  function automatic logic [7:0] ch_reg_data(input logic [2:0] idx);
    case (idx)
      3'd0:    ch_reg_data = 8'h00;
      3'd1:    ch_reg_data = 8'h48;
      3'd2:    ch_reg_data = 8'h80;
      3'd3:    ch_reg_data = 8'h09;
      3'd4:    ch_reg_data = 8'h08;
      3'd5:    ch_reg_data = 8'h16;
      3'd6:    ch_reg_data = 8'h60;
      default: ch_reg_data = 8'hC0;
    endcase
  endfunction

endpackage

// File: rtl/config_delay_counter.sv
// One-shot down counter: start loads a cycle count, expire is high during the
// final cycle of the interval. A start in the expire cycle re-arms it.
module config_delay_counter #(
  parameter int unsigned WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             start,
  input  logic [WIDTH-1:0] load_val,
  output logic             expire
);

  logic [WIDTH-1:0] cnt_q;
  logic             active_q;

  assign expire = active_q && (cnt_q == '0);

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else if (start) begin
      active_q <= 1'b1;
      // A zero load behaves like a one-cycle interval.
      cnt_q    <= (load_val == '0) ? '0 : load_val - WIDTH'(1);
    end else if (expire) begin
      active_q <= 1'b0;
    end else if (active_q) begin
      cnt_q <= cnt_q - WIDTH'(1);
    end
  end

endmodule

// File: rtl/chrontel_config_sequencer.sv
// Resets the Chrontel DVI transmitter and writes its init table over I2C with
// per-entry retry. Define CHRONTEL_CFG_READBACK_EN to verify each write by readback.
module chrontel_config_sequencer
  import chrontel_pkg::*;
#(
  parameter int unsigned RESET_HOLD_CYCLES    = 1000,
  parameter int unsigned RESET_RECOVER_CYCLES = 1000,
  parameter int unsigned MAX_RETRIES          = 3,
  parameter logic [6:0]  DEV_ADDR             = 7'h76
) (
  input  logic       clk,
  input  logic       rst_b,
  input  logic       start,
  output logic       i2c_req_valid,
  input  logic       i2c_req_ready,
  output logic [6:0] i2c_req_dev,
  output logic       i2c_req_rw,
  output logic [7:0] i2c_req_addr,
  output logic [7:0] i2c_req_data,
  input  logic       i2c_rsp_valid,
  input  logic       i2c_rsp_nack,
  input  logic [7:0] i2c_rsp_data,
  output logic       dvi_reset_b,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [2:0] err_index
);

  localparam int unsigned MaxDelay = (RESET_HOLD_CYCLES > RESET_RECOVER_CYCLES) ?
                                     RESET_HOLD_CYCLES : RESET_RECOVER_CYCLES;
  localparam int unsigned CntW     = (MaxDelay < 2) ? 1 : $clog2(MaxDelay + 1);
  localparam int unsigned RetryW   = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1);

  ch_state_e         state_q;
  logic [2:0]        index_q;
  logic [RetryW-1:0] retry_q;
  logic              cnt_start;
  logic              cnt_expire;
  logic [CntW-1:0]   cnt_load;
  logic              rsp_fail;

  assign i2c_req_dev = DEV_ADDR;

  // One counter times both reset phases; recover is armed in the hold expire cycle.
  always_comb begin
    cnt_start = 1'b0;
    cnt_load  = CntW'(RESET_HOLD_CYCLES);
    if ((state_q == StIdle || state_q == StDone || state_q == StError) && start) begin
      cnt_start = 1'b1;
    end else if (state_q == StRstHold && cnt_expire) begin
      cnt_start = 1'b1;
      cnt_load  = CntW'(RESET_RECOVER_CYCLES);
    end
  end

  config_delay_counter #(
    .WIDTH(CntW)
  ) u_delay (
    .clk     (clk),
    .rst_b   (rst_b),
    .start   (cnt_start),
    .load_val(cnt_load),
    .expire  (cnt_expire)
  );

  always_comb begin
    rsp_fail = i2c_rsp_nack;
`ifdef CHRONTEL_CFG_READBACK_EN
    if (state_q == StWaitRd && i2c_rsp_data != ch_reg_data(index_q)) begin
      rsp_fail = 1'b1;
    end
`endif
  end

`ifndef CHRONTEL_CFG_READBACK_EN
  logic unused_rsp_data;
  assign unused_rsp_data = ^i2c_rsp_data;
`endif

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q       <= StIdle;
      index_q       <= '0;
      retry_q       <= '0;
      dvi_reset_b   <= 1'b0;
      i2c_req_valid <= 1'b0;
      i2c_req_rw    <= 1'b0;
      i2c_req_addr  <= '0;
      i2c_req_data  <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
      err_index     <= '0;
    end else begin
      unique case (state_q)
        StIdle, StDone, StError: begin
          if (start) begin
            state_q     <= StRstHold;
            index_q     <= '0;
            retry_q     <= '0;
            dvi_reset_b <= 1'b0;
            busy        <= 1'b1;
            done        <= 1'b0;
            error       <= 1'b0;
            err_index   <= '0;
          end
        end
        StRstHold: begin
          if (cnt_expire) begin
            dvi_reset_b <= 1'b1;
            state_q     <= StRstRecover;
          end
        end
        StRstRecover: begin
          if (cnt_expire) begin
            state_q       <= StIssueWr;
            index_q       <= '0;
            i2c_req_valid <= 1'b1;
            i2c_req_rw    <= 1'b0;
            i2c_req_addr  <= ch_reg_addr(3'd0);
            i2c_req_data  <= ch_reg_data(3'd0);
          end
        end
        StIssueWr, StIssueRd: begin
          if (i2c_req_ready) begin
            i2c_req_valid <= 1'b0;
            state_q       <= (state_q == StIssueWr) ? StWaitWr : StWaitRd;
          end
        end
        StWaitWr, StWaitRd: begin
          if (i2c_rsp_valid) begin
            if (rsp_fail) begin
              if (retry_q < RetryW'(MAX_RETRIES)) begin
                retry_q       <= retry_q + RetryW'(1);
                state_q       <= StIssueWr;
                i2c_req_valid <= 1'b1;
                i2c_req_rw    <= 1'b0;
              end else begin
                state_q   <= StError;
                error     <= 1'b1;
                busy      <= 1'b0;
                err_index <= index_q;
              end
            end else if (state_q == StWaitWr) begin
`ifdef CHRONTEL_CFG_READBACK_EN
              state_q       <= StIssueRd;
              i2c_req_valid <= 1'b1;
              i2c_req_rw    <= 1'b1;
`else
              state_q <= StNext;
`endif
            end else begin
              state_q <= StNext;
            end
          end
        end
        StNext: begin
          retry_q <= '0;
          if (index_q == 3'(CH_NUM_REGS - 1)) begin
            state_q <= StDone;
            done    <= 1'b1;
            busy    <= 1'b0;
          end else begin
            index_q       <= index_q + 3'd1;
            state_q       <= StIssueWr;
            i2c_req_valid <= 1'b1;
            i2c_req_rw    <= 1'b0;
            i2c_req_addr  <= ch_reg_addr(index_q + 3'd1);
            i2c_req_data  <= ch_reg_data(index_q + 3'd1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_chrontel_config_sequencer.sv
// Bench for chrontel_config_sequencer: an I2C slave model with stall/NACK/readback
// fault injection and a scoreboard of expected requests in table order.
module tb_chrontel_config_sequencer;

  localparam int unsigned HOLD    = 10;
  localparam int unsigned RECOVER = 10;

  logic       clk = 1'b0;
  logic       rst_b = 1'b0;
  logic       start = 1'b0;
  logic       req_ready = 1'b0;
  logic       rsp_valid = 1'b0;
  logic       rsp_nack = 1'b0;
  logic [7:0] rsp_data = 8'h00;
  logic       req_valid;
  logic [6:0] req_dev;
  logic       req_rw;
  logic [7:0] req_addr;
  logic [7:0] req_data;
  logic       dvi_reset_b;
  logic       busy;
  logic       done;
  logic       error;
  logic [2:0] err_index;

  always #5 clk = ~clk;

  chrontel_config_sequencer #(
    .RESET_HOLD_CYCLES   (HOLD),
    .RESET_RECOVER_CYCLES(RECOVER),
    .MAX_RETRIES         (3),
    .DEV_ADDR            (7'h76)
  ) dut (
    .clk          (clk),
    .rst_b        (rst_b),
    .start        (start),
    .i2c_req_valid(req_valid),
    .i2c_req_ready(req_ready),
    .i2c_req_dev  (req_dev),
    .i2c_req_rw   (req_rw),
    .i2c_req_addr (req_addr),
    .i2c_req_data (req_data),
    .i2c_rsp_valid(rsp_valid),
    .i2c_rsp_nack (rsp_nack),
    .i2c_rsp_data (rsp_data),
    .dvi_reset_b  (dvi_reset_b),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .err_index    (err_index)
  );

  typedef struct packed {
    logic       rw;
    logic [7:0] addr;
    logic [7:0] data;
  } req_t;

  logic [7:0] tb_addr [8] = '{8'h1C, 8'h1D, 8'h1F, 8'h21, 8'h33, 8'h34, 8'h36, 8'h49};
  logic [7:0] tb_data [8] = '{8'h00, 8'h48, 8'h80, 8'h09, 8'h08, 8'h16, 8'h60, 8'hC0};

  req_t       exp_q[$];
  int         checks = 0;
  int         errors = 0;

  // Slave model knobs and observations
  logic [7:0] stall_addr = 8'h00;
  int         stall_left = 0;
  int         stall_seen = 0;
  int         unstable = 0;
  logic [7:0] nack_addr = 8'h00;
  int         nack_left = 0;
  logic [7:0] bad_rd_addr = 8'h00;
  logic       bad_rd_en = 1'b0;
  int         wr_cnt [256];
  logic [7:0] mem [256];

  // I2C slave model + scoreboard; inputs change on the falling edge only.
  initial begin
    bit         pending = 0;
    int         pend_delay = 0;
    logic       pend_nack = 0;
    logic [7:0] pend_data = 0;
    bit         prev_stalled = 0;
    req_t       snap = '0;
    req_t       cur;
    req_t       exp;
    forever begin
      @(negedge clk);
      rsp_valid = 1'b0;
      rsp_nack  = 1'b0;
      if (!rst_b) begin
        pending      = 0;
        prev_stalled = 0;
        req_ready    = 1'b0;
      end else begin
        if (pending) begin
          if (pend_delay == 0) begin
            rsp_valid = 1'b1;
            rsp_nack  = pend_nack;
            rsp_data  = pend_data;
            pending   = 0;
          end else begin
            pend_delay--;
          end
        end
        req_ready = 1'b0;
        if (req_valid) begin
          cur = '{rw: req_rw, addr: req_addr, data: req_data};
          if (prev_stalled && cur !== snap) unstable++;
          if (!req_rw && req_addr == stall_addr && stall_left > 0) begin
            if (!prev_stalled) snap = cur;
            prev_stalled = 1;
            stall_left--;
            stall_seen++;
          end else begin
            prev_stalled = 0;
            req_ready    = 1'b1;
            checks++;
            if (exp_q.size() == 0) begin
              errors++;
              $display("FAIL req_unexpected: got rw=%0d addr=%h data=%h, required no request",
                       req_rw, req_addr, req_data);
            end else begin
              exp = exp_q.pop_front();
              if (req_rw !== exp.rw || req_addr !== exp.addr || req_dev !== 7'h76 ||
                  (!exp.rw && req_data !== exp.data)) begin
                errors++;
                $display("FAIL req_order: got rw=%0d dev=%h addr=%h data=%h, required rw=%0d dev=76 addr=%h data=%h",
                         req_rw, req_dev, req_addr, req_data, exp.rw, exp.addr, exp.data);
              end
            end
            pending    = 1;
            pend_delay = 2;
            if (!req_rw) begin
              wr_cnt[req_addr]++;
              mem[req_addr] = req_data;
              pend_nack     = (req_addr == nack_addr && nack_left > 0);
              if (pend_nack) nack_left--;
              pend_data = 8'h00;
            end else begin
              pend_nack = 1'b0;
              pend_data = (bad_rd_en && req_addr == bad_rd_addr) ? 8'h00 : mem[req_addr];
            end
          end
        end else begin
          if (prev_stalled) unstable++;
          prev_stalled = 0;
        end
      end
    end
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached, required self-termination");
    $fatal(1, "watchdog");
  end

  task automatic clear_model();
    exp_q.delete();
    stall_left = 0;
    stall_seen = 0;
    unstable   = 0;
    nack_left  = 0;
    bad_rd_en  = 1'b0;
    for (int i = 0; i < 256; i++) wr_cnt[i] = 0;
  endtask

  task automatic push_write(input int i);
    exp_q.push_back('{rw: 1'b0, addr: tb_addr[i], data: tb_data[i]});
  endtask

  task automatic push_entry(input int i);
    push_write(i);
`ifdef CHRONTEL_CFG_READBACK_EN
    exp_q.push_back('{rw: 1'b1, addr: tb_addr[i], data: tb_data[i]});
`endif
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_finish(input string name);
    int n = 0;
    while (!(done || error) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!(done || error)) begin
      errors++;
      $display("FAIL %s_timeout: done=%0d error=%0d after %0d cycles, required completion",
               name, done, error, n);
    end
  endtask

  task automatic test_reset();
    rst_b = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({req_valid, busy, done, error, dvi_reset_b} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl: valid/busy/done/error/dvi=%b, required 00000",
               {req_valid, busy, done, error, dvi_reset_b});
    end
    checks++;
    if ({req_rw, req_addr, req_data, err_index} !== 20'h0) begin
      errors++;
      $display("FAIL reset_fields: rw=%0d addr=%h data=%h err_index=%0d, required all zero",
               req_rw, req_addr, req_data, err_index);
    end
    checks++;
    if (req_dev !== 7'h76) begin
      errors++;
      $display("FAIL reset_dev: got %h, required 76", req_dev);
    end
    rst_b = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic();
    int low_cnt = 0;
    int rec_cnt = 0;
    clear_model();
    for (int i = 0; i < 8; i++) push_entry(i);
    pulse_start();
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_busy: got %0d, required 1", busy);
    end
    while (dvi_reset_b === 1'b0 && low_cnt < 100) begin
      low_cnt++;
      @(negedge clk);
    end
    checks++;
    if (low_cnt != HOLD) begin
      errors++;
      $display("FAIL basic_hold: dvi_reset_b low %0d cycles, required %0d", low_cnt, HOLD);
    end
    while (!req_valid && dvi_reset_b === 1'b1 && rec_cnt < 100) begin
      rec_cnt++;
      @(negedge clk);
    end
    checks++;
    if (rec_cnt != RECOVER) begin
      errors++;
      $display("FAIL basic_recover: first request after %0d cycles, required %0d",
               rec_cnt, RECOVER);
    end
    wait_finish("basic");
    checks++;
    if ({done, busy, error, dvi_reset_b} !== 4'b1001 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL basic_end: done/busy/error/dvi=%b left=%0d, required 1001 left=0",
               {done, busy, error, dvi_reset_b}, exp_q.size());
    end
  endtask

  task automatic test_backpressure();
    clear_model();
    stall_addr = 8'h21;
    stall_left = 5;
    for (int i = 0; i < 8; i++) push_entry(i);
    pulse_start();
    wait_finish("backpressure");
    checks++;
    if (stall_seen != 5 || unstable != 0) begin
      errors++;
      $display("FAIL bp_stable: stalled %0d cycles with %0d changes, required 5 and 0",
               stall_seen, unstable);
    end
    checks++;
    if (wr_cnt[8'h21] != 1 || done !== 1'b1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL bp_accept: writes to 21=%0d done=%0d left=%0d, required 1 1 0",
               wr_cnt[8'h21], done, exp_q.size());
    end
  endtask

  task automatic test_nack_recover();
    clear_model();
    nack_addr = 8'h1F;
    nack_left = 2;
    push_entry(0);
    push_entry(1);
    push_write(2);
    push_write(2);
    for (int i = 2; i < 8; i++) push_entry(i);
    pulse_start();
    wait_finish("nack_recover");
    checks++;
    if (wr_cnt[8'h1F] != 3) begin
      errors++;
      $display("FAIL nack_rec_issues: entry 2 issued %0d times, required 3", wr_cnt[8'h1F]);
    end
    checks++;
    if ({done, error, busy} !== 3'b100 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL nack_rec_end: done/error/busy=%b left=%0d, required 100 left=0",
               {done, error, busy}, exp_q.size());
    end
  endtask

  task automatic test_nack_exhaust();
    clear_model();
    nack_addr = 8'h34;
    nack_left = 4;
    for (int i = 0; i < 5; i++) push_entry(i);
    for (int k = 0; k < 4; k++) push_write(5);
    pulse_start();
    wait_finish("nack_exhaust");
    repeat (20) @(negedge clk);
    checks++;
    if ({error, done, busy} !== 3'b100 || err_index !== 3'd5) begin
      errors++;
      $display("FAIL nack_exh_flags: error/done/busy=%b err_index=%0d, required 100 and 5",
               {error, done, busy}, err_index);
    end
    checks++;
    if (wr_cnt[8'h36] != 0 || wr_cnt[8'h34] != 4 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL nack_exh_reqs: entry5=%0d entry6=%0d left=%0d, required 4 0 0",
               wr_cnt[8'h34], wr_cnt[8'h36], exp_q.size());
    end
  endtask

`ifdef CHRONTEL_CFG_READBACK_EN
  task automatic test_readback_mismatch();
    clear_model();
    bad_rd_en   = 1'b1;
    bad_rd_addr = 8'h21;
    for (int i = 0; i < 3; i++) push_entry(i);
    for (int k = 0; k < 4; k++) push_entry(3);
    pulse_start();
    wait_finish("readback");
    repeat (10) @(negedge clk);
    checks++;
    if ({error, done} !== 2'b10 || err_index !== 3'd3 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL rb_mismatch: error/done=%b err_index=%0d left=%0d, required 10 3 0",
               {error, done}, err_index, exp_q.size());
    end
  endtask
`endif

  task automatic test_reset_midrun();
    int n = 0;
    clear_model();
    for (int i = 0; i < 4; i++) push_entry(i);
    push_write(4);
    pulse_start();
    while (wr_cnt[8'h33] == 0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (wr_cnt[8'h33] == 0) begin
      errors++;
      $display("FAIL midrun_reach: entry 4 write count 0, required 1");
    end
    @(posedge clk);
    #1 rst_b = 1'b0;
    #1;
    checks++;
    if ({req_valid, busy, done, error, dvi_reset_b, req_rw} !== 6'b0 ||
        {req_addr, req_data, err_index} !== 19'h0) begin
      errors++;
      $display("FAIL midrun_reset: valid/busy/done/error/dvi/rw=%b addr=%h data=%h, required all zero",
               {req_valid, busy, done, error, dvi_reset_b, req_rw}, req_addr, req_data);
    end
    repeat (2) @(negedge clk);
    rst_b = 1'b1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL midrun_prefix: %0d expected requests left, required 0", exp_q.size());
    end
    clear_model();
    for (int i = 0; i < 8; i++) push_entry(i);
    pulse_start();
    wait_finish("restart");
    checks++;
    if ({done, error} !== 2'b10 || wr_cnt[8'h1C] != 1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL restart_end: done/error=%b entry0=%0d left=%0d, required 10 1 0",
               {done, error}, wr_cnt[8'h1C], exp_q.size());
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    test_reset();
    test_basic();
    test_backpressure();
    test_nack_recover();
    test_nack_exhaust();
`ifdef CHRONTEL_CFG_READBACK_EN
    test_readback_mismatch();
`endif
    test_reset_midrun();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/chrontel_config_sequencer.md
CHRONTEL_CONFIG_SEQUENCER -- requirements
Module: chrontel_config_sequencer

Interface
REQ-001 SHALL have parameters (name, default, meaning):
- RESET_HOLD_CYCLES, 1000: cycles dvi_reset_b is held low.
- RESET_RECOVER_CYCLES, 1000: cycles waited after release, before the first I2C access.
- MAX_RETRIES, 3: re-issues allowed per table entry after a NACK or mismatch.
- DEV_ADDR, 7'h76: Chrontel 7-bit I2C address.
REQ-002 SHALL have ports (name, direction, width, meaning):
- clk, in, 1: single clock, all logic on posedge.
- rst_b, in, 1: asynchronous, active-low reset.
- start, in, 1: one-cycle pulse that begins a configuration run.
- i2c_req_valid, out, 1: transaction request.
- i2c_req_ready, in, 1: I2C master accepts the request.
- i2c_req_dev, out, 7: device address; always DEV_ADDR.
- i2c_req_rw, out, 1: 0 = write, 1 = read.
- i2c_req_addr, out, 8: Chrontel register address.
- i2c_req_data, out, 8: write data.
- i2c_rsp_valid, in, 1: transaction complete, one-cycle pulse.
- i2c_rsp_nack, in, 1: NACK seen; qualified by i2c_rsp_valid.
- i2c_rsp_data, in, 8: read data; qualified by i2c_rsp_valid.
- dvi_reset_b, out, 1: Chrontel reset, active low.
- busy, out, 1: a run is in progress.
- done, out, 1: sticky; all entries written.
- error, out, 1: sticky; retries exhausted.
- err_index, out, 3: table index of the failing entry.

Function
REQ-003 SHALL implement FSM states IDLE, RST_HOLD, RST_RECOVER, ISSUE_WR, WAIT_WR, ISSUE_RD, WAIT_RD, NEXT, DONE, ERROR.
REQ-004 SHALL, in IDLE/DONE/ERROR, on start: clear done, error and err_index; go to RST_HOLD; start is ignored while busy.
REQ-005 SHALL drive dvi_reset_b=0 for exactly RESET_HOLD_CYCLES cycles in RST_HOLD, then 1 for RESET_RECOVER_CYCLES cycles in RST_RECOVER, then go to ISSUE_WR with index 0.
REQ-006 SHALL walk the 8-entry init table in index order 0..7, one register per entry.
REQ-007 SHALL hold i2c_req_valid=1 and all i2c_req_* fields stable from ISSUE_WR entry until i2c_req_valid&&i2c_req_ready.
REQ-008 SHALL drop i2c_req_valid in the cycle after the handshake, then enter WAIT_WR; never more than one transaction outstanding.
REQ-009 SHALL, on i2c_rsp_valid in WAIT_WR:
- nack=0: go to ISSUE_RD when readback is compiled in (REQ-016), else NEXT.
- nack=1: count a retry.
REQ-010 SHALL on retry re-issue the same entry from ISSUE_WR while the retry count is below MAX_RETRIES; otherwise go to ERROR with err_index = current index.
REQ-011 SHALL, in NEXT: reset the retry count; if index==7 go to DONE, else increment index and go to ISSUE_WR.
REQ-012 SHALL set done=1, busy=0 in DONE; set error=1, busy=0 in ERROR; dvi_reset_b stays 1 in both.
REQ-013 SHALL ignore i2c_rsp_valid in any state other than WAIT_WR/WAIT_RD.
REQ-014 SHALL assert busy in every state except IDLE, DONE and ERROR.

Reset
REQ-015 SHALL, while rst_b=0 (asynchronously), force:
- state=IDLE; index=0; retry count=0; counters=0.
- dvi_reset_b=0; i2c_req_valid=0; busy=0; done=0; error=0; err_index=0.
- i2c_req_rw=0; i2c_req_addr=0; i2c_req_data=0.
A reset mid-transaction abandons it with no completion expected.

Configuration
REQ-016 SHALL, when CHRONTEL_CFG_READBACK_EN is defined, follow every acked write with a read:
- ISSUE_RD issues i2c_req_rw=1 to the same address.
- WAIT_RD: nack=1, or i2c_rsp_data differing from the table data, counts a retry per REQ-010.
- WAIT_RD: a matching response goes to NEXT.
REQ-017 SHALL, when CHRONTEL_CFG_READBACK_EN is undefined, never issue reads; i2c_req_rw is constantly 0 and ISSUE_RD/WAIT_RD are unreachable.

Structure
REQ-018 SHALL take its shared definitions from package chrontel_pkg:
- state enum.
- CH_NUM_REGS = 8.
- Init table as address/data constants: 1C/00, 1D/48, 1F/80, 21/09, 33/08, 34/16, 36/60, 49/C0.
REQ-019 SHALL instantiate one sub-module, config_delay_counter (load value, start, expire pulse), shared by RST_HOLD and RST_RECOVER.

Verification
REQ-020 SHALL cover (bench I2C model with RESET_HOLD_CYCLES = RESET_RECOVER_CYCLES = 10):
- Basic run: start; model acks everything -> dvi_reset_b low exactly 10 cycles, then high; 8 writes in table order (0x1C/0x00 first, 0x49/0xC0 last); done=1, busy=0.
- Ready backpressure: model holds i2c_req_ready=0 for 5 cycles on entry 3 -> valid and fields stable throughout; exactly one request accepted.
- NACK recovery: model NACKs entry 2 twice, then acks -> entry 2 issued 3 times; run completes with done=1.
- NACK exhaustion: model NACKs entry 5 four times -> error=1, err_index=5, done=0; no request for entry 6.
- Readback mismatch (READBACK_EN defined): model returns 0x00 for reg 0x21 every time -> error=1, err_index=3.
- Reset mid-run: rst_b low during WAIT_WR of entry 4 -> all outputs at reset values immediately; a later start restarts from entry 0.
